// File: rtl/mul16_shift_add_if.sv
// Handshake and adder-bus bundle for the shift-add multiplier.
// slave is the multiplier side; master is the requester plus external adder.
interface mul16_shift_add_if #(
    parameter int N_BITS = 16
);
    localparam int P_BITS = 2 * N_BITS;

    logic              start;
    logic [N_BITS-1:0] op_a;
    logic [N_BITS-1:0] op_b;
    logic              busy;
    logic              done;
    logic [P_BITS-1:0] product;
    logic              add_err;
    logic [P_BITS-1:0] add_a;
    logic [P_BITS-1:0] add_b;
    logic              add_cin;
    logic [P_BITS-1:0] add_s;
    logic              add_cout;

    modport slave (
        input  start, op_a, op_b, add_s, add_cout,
        output busy, done, product, add_err, add_a, add_b, add_cin
    );

    modport master (
        output start, op_a, op_b, add_s, add_cout,
        input  busy, done, product, add_err, add_a, add_b, add_cin
    );
endinterface

// File: rtl/mul16_shift_add.sv
// Unsigned N_BITS x N_BITS shift-add multiplier, fixed N_BITS iterations,
// using an external combinational adder for every partial-product step.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one add/shift iteration per cycle, N_BITS cycles
// DONE  | one-cycle done pulse; a new start is accepted here too
module mul16_shift_add #(
    parameter int N_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    mul16_shift_add_if.slave bus
);
    localparam int P_BITS = 2 * N_BITS;
    localparam int CNT_W  = $clog2(N_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [P_BITS-1:0] acc;
    logic [P_BITS-1:0] mcand;
    logic [N_BITS-1:0] mplier;
    logic [CNT_W-1:0]  count;
    logic [P_BITS-1:0] product_q;
    logic              busy_q;
    logic              done_q;
    logic              add_err_q;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.add_err = add_err_q;

    // Adder inputs are forced to zero outside RUN so the adder sits quiet.
    assign bus.add_a   = (state == RUN) ? acc : '0;
    assign bus.add_b   = (state == RUN && mplier[0]) ? mcand : '0;
    assign bus.add_cin = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            add_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand     <= {{N_BITS{1'b0}}, bus.op_a};
                        mplier    <= bus.op_b;
                        acc       <= '0;
                        count     <= '0;
                        add_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= bus.add_s;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (bus.add_cout) add_err_q <= 1'b1;
                    if (count == LAST) begin
                        product_q <= bus.add_s;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul16_shift_add.sv
// Directed bench for mul16_shift_add with a behavioural 32-bit adder that can
// be made to raise a spurious carry-out.
module tb_mul16_shift_add;
    logic clk = 1'b0;
    logic rst_n;
    logic force_cout;
    logic cout_m;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mul16_shift_add_if #(.N_BITS(16)) bus ();

    mul16_shift_add #(.N_BITS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign {cout_m, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};
    assign bus.add_cout = cout_m | force_cout;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full operation from start to one cycle past done. inj_at: edge at which a
    // stray start (with new operands) is presented during RUN; fault_at: edge at
    // which the adder carry-out is forced high. -1 disables either.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_p, input logic exp_err,
                         input string tag, input int inj_at, input int fault_at,
                         output logic [31:0] addb_or);
        int   extra_done;
        logic bad_busy;
        extra_done = 0;
        bad_busy   = 1'b0;
        addb_or    = '0;
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        tick();
        bus.start = 1'b0;
        bus.op_a  = 16'hA5A5;
        bus.op_b  = 16'h5A5A;
        chk({tag, " busy@E0"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, " add_err cleared@E0"}, {31'd0, bus.add_err}, 32'd0);
        for (int k = 1; k <= 16; k++) begin
            addb_or    = addb_or | bus.add_b;
            force_cout = (k == fault_at);
            bus.start  = (k == inj_at);
            if (k == inj_at) begin
                bus.op_a = 16'hFFFF;
                bus.op_b = 16'hFFFF;
            end
            tick();
            if (k < 16) begin
                if (!bus.busy) bad_busy = 1'b1;
                if (bus.done) extra_done++;
            end
        end
        force_cout = 1'b0;
        bus.start  = 1'b0;
        chk({tag, " busy@E16"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, " done@E16"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " product@E16"}, bus.product, exp_p);
        chk({tag, " add_err@E16"}, {31'd0, bus.add_err}, {31'd0, exp_err});
        tick();
        chk({tag, " done@E17"}, {31'd0, bus.done}, 32'd0);
        repeat (2) begin
            tick();
            if (bus.done || bus.busy) extra_done++;
        end
        chk({tag, " busy in RUN"}, {31'd0, bad_busy}, 32'd0);
        chk({tag, " stray done/busy"}, extra_done, 32'd0);
        chk({tag, " product held"}, bus.product, exp_p);
        chk({tag, " add_err held"}, {31'd0, bus.add_err}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] addb_or;
        int          cnt;
        force_cout = 1'b0;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        rst_n      = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset product", bus.product, 32'd0);
        chk("reset add_err", {31'd0, bus.add_err}, 32'd0);
        #10 rst_n = 1'b1;
        cnt = 0;
        repeat (5) begin
            tick();
            if (bus.busy || bus.done || bus.add_a != 0 || bus.add_b != 0) cnt++;
        end
        chk("idle quiet", cnt, 32'd0);

        do_op(16'd3, 16'd5, 32'h0000000F, 1'b0, "3x5", -1, -1, addb_or);
        do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, "max", -1, -1, addb_or);
        do_op(16'h1234, 16'h0000, 32'h00000000, 1'b0, "zero_b", -1, -1, addb_or);
        chk("zero_b add_b in RUN", addb_or, 32'd0);
        do_op(16'h00FF, 16'h0100, 32'h0000FF00, 1'b0, "start_in_run", 5, -1, addb_or);

        // Back-to-back: start held through DONE.
        bus.start = 1'b1;
        bus.op_a  = 16'd7;
        bus.op_b  = 16'd9;
        tick();
        chk("b2b busy@E0", {31'd0, bus.busy}, 32'd1);
        bus.op_a = 16'h0010;
        bus.op_b = 16'h0011;
        cnt = 0;
        repeat (15) begin
            tick();
            if (bus.done) cnt++;
        end
        tick();
        chk("b2b done@E16", {31'd0, bus.done}, 32'd1);
        chk("b2b product@E16", bus.product, 32'd63);
        tick();
        bus.start = 1'b0;
        chk("b2b done@E17", {31'd0, bus.done}, 32'd0);
        chk("b2b busy@E17", {31'd0, bus.busy}, 32'd1);
        chk("b2b product held@E17", bus.product, 32'd63);
        repeat (15) begin
            tick();
            if (bus.done) cnt++;
        end
        tick();
        chk("b2b done@E33", {31'd0, bus.done}, 32'd1);
        chk("b2b product@E33", bus.product, 32'h00000110);
        chk("b2b single done each", cnt, 32'd0);
        tick();

        do_op(16'd3, 16'd5, 32'h0000000F, 1'b1, "fault", -1, 4, addb_or);
        do_op(16'd2, 16'd2, 32'h00000004, 1'b0, "after_fault", -1, -1, addb_or);

        // Abort mid-RUN with an asynchronous reset.
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h00FF;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        chk("abort acc@E8", bus.add_a, 32'h001221CC);
        chk("abort busy@E8", {31'd0, bus.busy}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("abort busy", {31'd0, bus.busy}, 32'd0);
        chk("abort product", bus.product, 32'd0);
        chk("abort add_a", bus.add_a, 32'd0);
        #2 rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            if (bus.done || bus.busy || bus.add_a != 0) cnt++;
        end
        chk("abort no done", cnt, 32'd0);
        chk("abort product stays 0", bus.product, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
